// File: rtl/alu_rs_if.sv
// Bundle of the dispatch, result-broadcast and issue signals of the ALU
// reservation station. The station itself takes the slave side; whoever
// drives dispatches and broadcasts (decoder/CDB, or a bench) takes master.
//
// Handshake: a dispatch transfers on a rising edge where disp_valid_in=1 and
// full_out=0; there is no other back-pressure. Broadcasts (alu_cdb_*,
// lsb_cdb_*) are single-cycle strobes qualified by their *_ready_in bit.
// alu_valid_out is a one-cycle issue strobe with no ready return.
interface alu_rs_if #(
    parameter int ROB_WIDTH = 4
);
    // dispatch
    logic                 disp_valid_in;
    logic [2:0]           disp_op_L1_in;
    logic                 disp_op_L2_in;
    logic [31:0]          disp_vj_in;
    logic [31:0]          disp_vk_in;
    logic                 disp_qj_valid_in;
    logic                 disp_qk_valid_in;
    logic [ROB_WIDTH-1:0] disp_qj_in;
    logic [ROB_WIDTH-1:0] disp_qk_in;
    logic [ROB_WIDTH-1:0] disp_rob_id_in;

    // result broadcasts
    logic                 alu_cdb_ready_in;
    logic [ROB_WIDTH-1:0] alu_cdb_rob_id_in;
    logic [31:0]          alu_cdb_value_in;
    logic                 lsb_cdb_ready_in;
    logic [ROB_WIDTH-1:0] lsb_cdb_rob_id_in;
    logic [31:0]          lsb_cdb_value_in;

    // status and issue
    logic                 full_out;
    logic                 alu_valid_out;
    logic [31:0]          alu_opr1_out;
    logic [31:0]          alu_opr2_out;
    logic [2:0]           alu_op_L1_out;
    logic                 alu_op_L2_out;
    logic [ROB_WIDTH-1:0] alu_rob_id_out;

    modport master (
        output disp_valid_in, disp_op_L1_in, disp_op_L2_in,
        output disp_vj_in, disp_vk_in,
        output disp_qj_valid_in, disp_qk_valid_in, disp_qj_in, disp_qk_in,
        output disp_rob_id_in,
        output alu_cdb_ready_in, alu_cdb_rob_id_in, alu_cdb_value_in,
        output lsb_cdb_ready_in, lsb_cdb_rob_id_in, lsb_cdb_value_in,
        input  full_out, alu_valid_out, alu_opr1_out, alu_opr2_out,
        input  alu_op_L1_out, alu_op_L2_out, alu_rob_id_out
    );

    modport slave (
        input  disp_valid_in, disp_op_L1_in, disp_op_L2_in,
        input  disp_vj_in, disp_vk_in,
        input  disp_qj_valid_in, disp_qk_valid_in, disp_qj_in, disp_qk_in,
        input  disp_rob_id_in,
        input  alu_cdb_ready_in, alu_cdb_rob_id_in, alu_cdb_value_in,
        input  lsb_cdb_ready_in, lsb_cdb_rob_id_in, lsb_cdb_value_in,
        output full_out, alu_valid_out, alu_opr1_out, alu_opr2_out,
        output alu_op_L1_out, alu_op_L2_out, alu_rob_id_out
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station. Holds dispatched integer ops until both operands
// are known (snooping the ALU and LSB result broadcasts), then issues the
// lowest-index ready entry to the ALU through a registered output stage.
// Readiness and slot choice are always taken from pre-edge state, so an
// entry written or woken at an edge can issue no earlier than the next one.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    input  logic    flush_in,
    alu_rs_if.slave bus
);

    // entry storage
    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_qj_valid;
    logic [RS_SIZE-1:0]   r_qk_valid;
    logic [2:0]           r_op_l1  [RS_SIZE];
    logic                 r_op_l2  [RS_SIZE];
    logic [31:0]          r_vj     [RS_SIZE];
    logic [31:0]          r_vk     [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qk     [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_rob_id [RS_SIZE];

    // issue output stage
    logic                 r_alu_valid;
    logic [31:0]          r_alu_opr1;
    logic [31:0]          r_alu_opr2;
    logic [2:0]           r_alu_op_l1;
    logic                 r_alu_op_l2;
    logic [ROB_WIDTH-1:0] r_alu_rob_id;

    // selection and wakeup helpers
    logic                 w_full;
    logic [RS_SIZE-1:0]   w_ready;
    logic                 w_free_found;
    logic [RS_WIDTH-1:0]  w_free_idx;
    logic                 w_issue_found;
    logic [RS_WIDTH-1:0]  w_issue_idx;
    logic                 w_disp_accept;
    logic [RS_SIZE-1:0]   w_j_alu_hit;
    logic [RS_SIZE-1:0]   w_j_lsb_hit;
    logic [RS_SIZE-1:0]   w_k_alu_hit;
    logic [RS_SIZE-1:0]   w_k_lsb_hit;
    logic                 w_dj_alu_hit;
    logic                 w_dj_lsb_hit;
    logic                 w_dk_alu_hit;
    logic                 w_dk_lsb_hit;
    logic                 w_disp_qj_valid;
    logic                 w_disp_qk_valid;
    logic [31:0]          w_disp_vj;
    logic [31:0]          w_disp_vk;

    // full is purely a function of the busy bits; an entry issuing this
    // cycle still counts as occupied
    assign w_full        = &r_busy;
    assign w_ready       = r_busy & ~r_qj_valid & ~r_qk_valid;
    assign w_disp_accept = bus.disp_valid_in && !w_full;

    // lowest-index free slot (descending scan so the lowest match wins)
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_WIDTH'(i);
            end
        end
    end

    // lowest-index ready entry
    always_comb begin
        w_issue_found = 1'b0;
        w_issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_issue_found = 1'b1;
                w_issue_idx   = RS_WIDTH'(i);
            end
        end
    end

    // per-entry tag matches against both broadcast buses
    always_comb begin
        w_j_alu_hit = '0;
        w_j_lsb_hit = '0;
        w_k_alu_hit = '0;
        w_k_lsb_hit = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_j_alu_hit[i] = r_busy[i] && r_qj_valid[i] && bus.alu_cdb_ready_in
                             && (r_qj[i] == bus.alu_cdb_rob_id_in);
            w_j_lsb_hit[i] = r_busy[i] && r_qj_valid[i] && bus.lsb_cdb_ready_in
                             && (r_qj[i] == bus.lsb_cdb_rob_id_in);
            w_k_alu_hit[i] = r_busy[i] && r_qk_valid[i] && bus.alu_cdb_ready_in
                             && (r_qk[i] == bus.alu_cdb_rob_id_in);
            w_k_lsb_hit[i] = r_busy[i] && r_qk_valid[i] && bus.lsb_cdb_ready_in
                             && (r_qk[i] == bus.lsb_cdb_rob_id_in);
        end
    end

    // dispatch bypass: a tag being broadcast this very cycle is stored as a
    // resolved value, otherwise the entry would miss its only wakeup
    always_comb begin
        w_dj_alu_hit = bus.disp_qj_valid_in && bus.alu_cdb_ready_in
                       && (bus.disp_qj_in == bus.alu_cdb_rob_id_in);
        w_dj_lsb_hit = bus.disp_qj_valid_in && bus.lsb_cdb_ready_in
                       && (bus.disp_qj_in == bus.lsb_cdb_rob_id_in);
        w_dk_alu_hit = bus.disp_qk_valid_in && bus.alu_cdb_ready_in
                       && (bus.disp_qk_in == bus.alu_cdb_rob_id_in);
        w_dk_lsb_hit = bus.disp_qk_valid_in && bus.lsb_cdb_ready_in
                       && (bus.disp_qk_in == bus.lsb_cdb_rob_id_in);

        w_disp_qj_valid = bus.disp_qj_valid_in && !w_dj_alu_hit && !w_dj_lsb_hit;
        w_disp_qk_valid = bus.disp_qk_valid_in && !w_dk_alu_hit && !w_dk_lsb_hit;

        // ALU value takes precedence when both buses carry the same tag
        if (w_dj_alu_hit) begin
            w_disp_vj = bus.alu_cdb_value_in;
        end else if (w_dj_lsb_hit) begin
            w_disp_vj = bus.lsb_cdb_value_in;
        end else begin
            w_disp_vj = bus.disp_vj_in;
        end

        if (w_dk_alu_hit) begin
            w_disp_vk = bus.alu_cdb_value_in;
        end else if (w_dk_lsb_hit) begin
            w_disp_vk = bus.lsb_cdb_value_in;
        end else begin
            w_disp_vk = bus.disp_vk_in;
        end
    end

    // entry state: reset/flush clear, then wakeup, issue retire and dispatch.
    // These touch disjoint slots: wakeup only pending busy entries, issue
    // only a ready busy entry, dispatch only a slot that was free pre-edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy     <= '0;
            r_qj_valid <= '0;
            r_qk_valid <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (w_j_alu_hit[i]) begin
                        r_vj[i]       <= bus.alu_cdb_value_in;
                        r_qj_valid[i] <= 1'b0;
                    end else if (w_j_lsb_hit[i]) begin
                        r_vj[i]       <= bus.lsb_cdb_value_in;
                        r_qj_valid[i] <= 1'b0;
                    end
                    if (w_k_alu_hit[i]) begin
                        r_vk[i]       <= bus.alu_cdb_value_in;
                        r_qk_valid[i] <= 1'b0;
                    end else if (w_k_lsb_hit[i]) begin
                        r_vk[i]       <= bus.lsb_cdb_value_in;
                        r_qk_valid[i] <= 1'b0;
                    end
                end

                if (w_issue_found) begin
                    r_busy[w_issue_idx] <= 1'b0;
                end

                if (w_disp_accept && w_free_found) begin
                    r_busy[w_free_idx]     <= 1'b1;
                    r_op_l1[w_free_idx]    <= bus.disp_op_L1_in;
                    r_op_l2[w_free_idx]    <= bus.disp_op_L2_in;
                    r_vj[w_free_idx]       <= w_disp_vj;
                    r_vk[w_free_idx]       <= w_disp_vk;
                    r_qj_valid[w_free_idx] <= w_disp_qj_valid;
                    r_qk_valid[w_free_idx] <= w_disp_qk_valid;
                    r_qj[w_free_idx]       <= bus.disp_qj_in;
                    r_qk[w_free_idx]       <= bus.disp_qk_in;
                    r_rob_id[w_free_idx]   <= bus.disp_rob_id_in;
                end
            end
        end
    end

    // issue stage: load the selected entry; payload holds when nothing issues
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_alu_valid  <= 1'b0;
            r_alu_opr1   <= '0;
            r_alu_opr2   <= '0;
            r_alu_op_l1  <= '0;
            r_alu_op_l2  <= 1'b0;
            r_alu_rob_id <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_alu_valid <= 1'b0;
            end else if (w_issue_found) begin
                r_alu_valid  <= 1'b1;
                r_alu_opr1   <= r_vj[w_issue_idx];
                r_alu_opr2   <= r_vk[w_issue_idx];
                r_alu_op_l1  <= r_op_l1[w_issue_idx];
                r_alu_op_l2  <= r_op_l2[w_issue_idx];
                r_alu_rob_id <= r_rob_id[w_issue_idx];
            end else begin
                r_alu_valid <= 1'b0;
            end
        end
    end

    assign bus.full_out       = w_full;
    assign bus.alu_valid_out  = r_alu_valid;
    assign bus.alu_opr1_out   = r_alu_opr1;
    assign bus.alu_opr2_out   = r_alu_opr2;
    assign bus.alu_op_L1_out  = r_alu_op_l1;
    assign bus.alu_op_L2_out  = r_alu_op_l2;
    assign bus.alu_rob_id_out = r_alu_rob_id;

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that buffers dispatched integer ALU ops and tracks operand readiness by snooping two result broadcasts (ALU and LSB).
- Issues at most one ready entry per cycle to the ALU as a registered, ROB-tagged op.
- Sits between the dispatcher/decoder and the ALU in the Tomasulo out-of-order core.

Parameters:
RS_SIZE, 8, number of entries
RS_WIDTH, 3, log2(RS_SIZE)
ROB_WIDTH, 4, ROB tag width

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  synchronous reset, active-high
rdy_in  in  1  global enable; low = freeze all state and outputs
flush_in  in  1  mispredict flush; clears all entries
disp_valid_in  in  1  dispatch request
disp_op_L1_in  in  3  ALU major op (ADD_SUB..AND encoding)
disp_op_L2_in  in  1  ALU minor op (SUB/SRA select)
disp_vj_in, disp_vk_in  in  32 each  operand values, meaningful when tag not pending
disp_qj_valid_in, disp_qk_valid_in  in  1 each  operand pending on a ROB tag
disp_qj_in, disp_qk_in  in  ROB_WIDTH each  producer ROB tags
disp_rob_id_in  in  ROB_WIDTH  destination ROB tag
alu_cdb_ready_in  in  1  ALU broadcast valid
alu_cdb_rob_id_in  in  ROB_WIDTH  ALU broadcast tag
alu_cdb_value_in  in  32  ALU broadcast value
lsb_cdb_ready_in  in  1  LSB broadcast valid
lsb_cdb_rob_id_in  in  ROB_WIDTH  LSB broadcast tag
lsb_cdb_value_in  in  32  LSB broadcast value
full_out  out  1  no free entry (combinational from registered state)
alu_valid_out  out  1  issue strobe to ALU (registered)
alu_opr1_out, alu_opr2_out  out  32 each  issued operands (registered)
alu_op_L1_out  out  3  issued major op
alu_op_L2_out  out  1  issued minor op
alu_rob_id_out  out  ROB_WIDTH  issued ROB tag

Behaviour:
- Clocking: one clock, synchronous active-high reset. Priority at each edge: rst_in > !rdy_in (hold everything) > flush_in > normal.
- Reset: all busy bits 0. All outputs 0; full_out 0.
- Flush: all busy bits cleared, alu_valid_out <= 0, dispatch in that cycle dropped. full_out is 0 in the following cycle.
- Entry state: busy, op_L1, op_L2, vj, vk, qj_valid, qj, qk_valid, qk, rob_id.
- Dispatch:
  - Accepted when disp_valid_in && !full_out; written into the lowest-index free entry.
  - Dispatcher must not assert disp_valid_in while full_out=1; if it does, the request is ignored.
- Dispatch bypass: a disp tag matching a same-cycle broadcast (ALU or LSB, valid high) is stored as resolved with the broadcast value.
- Wakeup: each busy entry with q*_valid and a tag equal to a valid broadcast tag captures the value and clears q*_valid at the edge. Both operands may wake in the same cycle, from the same or different buses. If both buses carry the same tag, the ALU value wins.
- Ready: busy && !qj_valid && !qk_valid, evaluated on registered state.
  - An entry woken or dispatched at edge E is issue-eligible in the cycle after E.
  - Selection and wakeup never combine in one cycle.
- Issue: lowest-index ready entry. At the edge:
  - outputs load vj, vk, op_L1, op_L2, rob_id;
  - alu_valid_out <= 1;
  - the entry's busy bit is cleared.
  - With no ready entry, alu_valid_out <= 0 and the other outputs hold.
- Latency: a dispatch with both operands ready at edge N gives alu_valid_out=1 after edge N+1; the ALU result is visible after edge N+2.
- Simultaneous dispatch and issue: both occur. The free slot is chosen from pre-edge state, so the slot being issued is not reused in the same cycle.
- full_out: asserted whenever all RS_SIZE entries are busy, even in a cycle where one entry issues (conservative).
- Age order is not guaranteed; index priority only.

Test Plan:
- Reset, then dispatch ADD (L1=000, L2=0), vj=5, vk=7, rob_id=3, both ready, at edge N -> after edge N+1: alu_valid_out=1, opr1=5, opr2=7, rob_id_out=3; after edge N+2: alu_valid_out=0.
- Dispatch SUB with qj pending on tag 6, vk=2, rob_id=1; two cycles later drive alu_cdb tag 6, value 10 -> issue is held until then; alu_valid_out=1 one cycle after the wakeup edge, opr1=10, opr2=2, op_L2=1.
- Dispatch with qk tag 4 in the same cycle as lsb_cdb tag 4, value 0xFFFF_FFF0 -> operand captured via bypass; issued next cycle with opr2=0xFFFF_FFF0.
- Dispatch 8 entries all pending on tag 9 -> full_out=1 and a 9th dispatch is dropped. Broadcast tag 9 -> entries 0..7 issue in index order, one per cycle; full_out falls after the first issue edge.
- Fill 3 entries, then assert flush_in together with a ready dispatch -> next cycle: full_out=0, alu_valid_out=0, no issue in any later cycle; the rdy_in=0 cycle after that freezes the outputs.
- Assert rst_in while entries are busy and alu_valid_out=1 -> after the edge all outputs are 0; a later broadcast of the old tags produces no issue.
